lc3_microsequencer: RTL
=======================

Name: lc3_microsequencer

Overview:
- Upstream neighbour of the LC-3 control store. Holds the current microstate register that drives the control store read address and read enable.
- Each cycle it computes the next microstate from fields of the current microinstruction (J, COND, IRD) plus datapath status: IR, BEN, memory ready R, interrupt, PSR[15].
- Also owns the BEN register and a memory-wait watchdog.

Parameters:
- ADDR_W, 6, microstate address width; matches the control store address bus.
- RESET_STATE, 18, microstate loaded on reset (fetch state).
- MAX_WAIT, 255, consecutive memory-wait cycles before o_mem_timeout sets; range 1..2^WAIT_W-1.
- WAIT_W, 8, watchdog counter width.

Ports:
- i_CLK, input, 1, system clock; all state updates on the rising edge.
- i_RST, input, 1, asynchronous active-high reset.
- i_J, input, ADDR_W, J field of the current microinstruction.
- i_COND, input, 3, COND field of the current microinstruction.
- i_IRD, input, 1, IRD field; selects opcode dispatch.
- i_LD_BEN, input, 1, load enable for the BEN register.
- i_IR, input, 16, instruction register contents.
- i_N, i_Z, i_P, input, 1 each, condition codes.
- i_R, input, 1, memory ready.
- i_INT, input, 1, pending interrupt.
- i_PSR15, input, 1, privilege bit (1 = user).
- o_state_addr, output, ADDR_W, current microstate; drives the control store read address.
- o_cs_en, output, 1, control store read enable.
- o_BEN, output, 1, registered branch-enable.
- o_mem_timeout, output, 1, sticky watchdog flag.

Behaviour:
- Reset (asynchronous, any time, including mid-wait or mid-instruction):
  - o_state_addr = RESET_STATE, o_cs_en = 0, o_BEN = 0, o_mem_timeout = 0, watchdog count = 0.
- Enable:
  - o_cs_en is registered. It goes to 1 on the first rising edge after i_RST deasserts and stays 1.
  - While o_cs_en = 0, the state register holds RESET_STATE and the watchdog does not count. The first fetched microinstruction is therefore RESET_STATE.
- Next-state selection (combinational from current inputs; registered on the edge when o_cs_en = 1; one cycle per microstate):
  - IRD = 1: next = {2'b00, i_IR[15:12]}. COND is ignored.
  - IRD = 0: next = i_J with one bit ORed, selected by COND:
    - 000: no modification.
    - 001: J[1] |= i_R.
    - 010: J[2] |= o_BEN.
    - 011: J[0] |= i_IR[11].
    - 100: J[3] |= i_PSR15.
    - 101: J[4] |= i_INT.
    - 110 and 111: treated as 000.
- BEN:
  - On an edge with i_LD_BEN = 1: o_BEN <= (i_IR[11] & i_N) | (i_IR[10] & i_Z) | (i_IR[9] & i_P).
  - Otherwise o_BEN holds.
  - COND = 010 always uses the pre-edge (registered) o_BEN, never the value being loaded on the same edge.
- Watchdog:
  - A wait cycle is one with o_cs_en = 1, IRD = 0, COND = 001 and i_R = 0. The count increments on each wait cycle and saturates at MAX_WAIT.
  - Any non-wait cycle clears the count.
  - When the count reaches MAX_WAIT, o_mem_timeout <= 1 on that edge. It stays set until reset.
  - The watchdog has no effect on sequencing; the FSM keeps waiting.
- Simultaneous events:
  - i_LD_BEN together with COND = 010: branch uses the old BEN, BEN updates.
  - i_R rising on the edge that would otherwise be the MAX_WAIT-th wait cycle: not a wait cycle, so no timeout and the count clears.
- No combinational path exists from o_state_addr back to itself except through the control store fields. Outputs are driven directly from registers.

Test Plan:
- Assert i_RST for 3 cycles, then release. Required: o_state_addr = 18 and o_cs_en = 0 during reset; o_cs_en = 1 after the first edge post-release; o_state_addr stays 18 until the second edge.
- IRD = 1, IR = 16'h1234. Required: next o_state_addr = 1. Then IR = 16'hF025. Required: next = 15.
- LD_BEN with IR[11:9] = 3'b010, N = 0, Z = 1, P = 0. Required: o_BEN = 1. The next cycle, COND = 010 with J = 6'd0. Required: next = 4. Repeat with Z = 0. Required: o_BEN = 0 and next = 0.
- COND = 001, J = 6'd16, R = 0 for 5 cycles, then R = 1. Required: state stays 16 for 5 edges, then goes to 18 when R = 1; watchdog count returns to 0.
- MAX_WAIT = 4, R held 0 in a wait state. Required: o_mem_timeout rises on the 4th wait edge and stays 1 after R = 1. Subsequent i_RST clears it.
- COND = 101, J = 6'd33, INT = 1. Required: next = 49. COND = 100, J = 6'd32, PSR15 = 1. Required: next = 40. Assert i_RST mid-sequence. Required: immediate return to 18 with o_cs_en = 0.

Source files
------------

// File: rtl/lc3_microsequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : lc3_microsequencer_if
// Brief    : Control-store fields, datapath status and sequencer outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface lc3_microsequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] i_J;
    logic [2:0]        i_COND;
    logic              i_IRD;
    logic              i_LD_BEN;
    logic [15:0]       i_IR;
    logic              i_N;
    logic              i_Z;
    logic              i_P;
    logic              i_R;
    logic              i_INT;
    logic              i_PSR15;
    logic [ADDR_W-1:0] o_state_addr;
    logic              o_cs_en;
    logic              o_BEN;
    logic              o_mem_timeout;

    // The sequencer side owns the address and status outputs.
    modport master (
        input  i_J, i_COND, i_IRD, i_LD_BEN, i_IR,
        input  i_N, i_Z, i_P, i_R, i_INT, i_PSR15,
        output o_state_addr, o_cs_en, o_BEN, o_mem_timeout
    );

    // The control store / datapath side supplies fields and status.
    modport slave (
        output i_J, i_COND, i_IRD, i_LD_BEN, i_IR,
        output i_N, i_Z, i_P, i_R, i_INT, i_PSR15,
        input  o_state_addr, o_cs_en, o_BEN, o_mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/lc3_microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : lc3_microsequencer
// Brief    : LC-3 microstate register, next-state select, BEN and memory watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_microsequencer #(
    parameter int ADDR_W      = 6,
    parameter int RESET_STATE = 18,
    parameter int MAX_WAIT    = 255,
    parameter int WAIT_W      = 8
) (
    input  wire                   i_CLK,
    input  wire                   i_RST,
    lc3_microsequencer_if.master  bus
);
    localparam logic [ADDR_W-1:0] c_reset_state = ADDR_W'(RESET_STATE);
    localparam logic [WAIT_W-1:0] c_max_wait    = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] c_max_wait_m1 = WAIT_W'(MAX_WAIT - 1);

    localparam logic [2:0] c_cond_none = 3'b000;
    localparam logic [2:0] c_cond_rdy  = 3'b001;
    localparam logic [2:0] c_cond_ben  = 3'b010;
    localparam logic [2:0] c_cond_ir11 = 3'b011;
    localparam logic [2:0] c_cond_psr  = 3'b100;
    localparam logic [2:0] c_cond_int  = 3'b101;

    logic [ADDR_W-1:0] r_state;
    logic              r_cs_en;
    logic              r_ben;
    logic              r_timeout;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic [ADDR_W-1:0] w_or_mask;
    logic [ADDR_W-1:0] w_next;
    logic              w_wait;
    logic              w_ben_new;

    always_comb begin
        w_or_mask = '0;
        case (bus.i_COND)
            c_cond_none: w_or_mask = '0;
            c_cond_rdy:  w_or_mask[1] = bus.i_R;
            c_cond_ben:  w_or_mask[2] = r_ben;
            c_cond_ir11: w_or_mask[0] = bus.i_IR[11];
            c_cond_psr:  w_or_mask[3] = bus.i_PSR15;
            c_cond_int:  w_or_mask[4] = bus.i_INT;
            default:     w_or_mask = '0;
        endcase
    end

    always_comb begin
        w_next = bus.i_J | w_or_mask;
        if (bus.i_IRD) begin
            w_next = {{(ADDR_W-4){1'b0}}, bus.i_IR[15:12]};
        end
    end

    assign w_wait    = r_cs_en & ~bus.i_IRD & (bus.i_COND == c_cond_rdy) & ~bus.i_R;
    assign w_ben_new = (bus.i_IR[11] & bus.i_N) | (bus.i_IR[10] & bus.i_Z) |
                       (bus.i_IR[9] & bus.i_P);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= c_reset_state;
            r_cs_en <= 1'b0;
        end else begin
            r_cs_en <= 1'b1;
            if (r_cs_en) begin
                r_state <= w_next;
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_ben <= 1'b0;
        end else if (bus.i_LD_BEN) begin
            r_ben <= w_ben_new;
        end
    end

    // The watchdog only observes; a stuck memory still leaves the FSM waiting.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (r_cs_en) begin
            if (w_wait) begin
                if (r_wait_cnt != c_max_wait) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (r_wait_cnt == c_max_wait_m1) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign bus.o_state_addr  = r_state;
    assign bus.o_cs_en       = r_cs_en;
    assign bus.o_BEN         = r_ben;
    assign bus.o_mem_timeout = r_timeout;

    wire w_unused = &{1'b0, bus.i_IR[8:0]};
endmodule
`default_nettype wire
